pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the load and squash inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Its decisions come from I-cache and D-cache handshakes, the EX-stage redirect, and the ID-stage load-use hazard. It latches early cache responses so that neither cache is re-requested while the other is still stalling, and it keeps stall, flush and timeout statistics.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters (wrap on overflow)
TIMEOUT, 1024, consecutive non-advancing cycles after which timeout_err sets

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imem_req  in  1  fetch access outstanding this cycle
imem_resp  in  1  I-cache response valid (single-cycle pulse)
dmem_req  in  1  EX/MEM holds a load/store (mem_read|mem_write of its control word)
dmem_resp  in  1  D-cache response valid (single-cycle pulse)
redirect  in  1  EX resolved a taken branch/jump (br_en or jal/jalr)
load_use  in  1  ID reads the rd of a load currently in ID/EX
load_pc  out  1  PC register load
load_if_id  out  1  IF/ID load
load_id_ex  out  1  ID/EX load
load_ex_mem  out  1  EX/MEM load
load_mem_wb  out  1  MEM/WB load
squash_if_id  out  1  IF/ID clear (effective with its load)
squash_id_ex  out  1  ID/EX clear (effective with its load)
mem_stall  out  1  pipeline frozen by a memory wait this cycle
stall_cnt  out  CNT_W  cycles with mem_stall=1
flush_cnt  out  CNT_W  redirects applied
timeout_err  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=RUN; i_done=0, d_done=0; both counters 0; wait counter 0; timeout_err=0. While rst=1, every load and squash output is 0 and mem_stall=0.
- Cache readiness:
  - i_ok = !imem_req | imem_resp | i_done
  - d_ok = !dmem_req | dmem_resp | d_done
  - advance = i_ok & d_ok
- State machine, two states:
  - RUN -> WAIT when advance=0.
  - WAIT -> RUN on the cycle advance=1 (that cycle is itself an advancing cycle).
  - RUN stays in RUN while advance=1.
- Done flags:
  - i_done sets on imem_resp when advance=0. d_done sets on dmem_resp when advance=0.
  - Both clear on any advancing cycle.
  - A resp arriving on the advancing cycle does not set its flag.
- mem_stall = !advance. When advance=0, every load and squash output is 0.
- Advancing cycle, priority order (first match wins):
  1. redirect=1: all five loads=1, squash_if_id=1, squash_id_ex=1, flush_cnt+1. load_use is ignored because the hazarding instruction is flushed.
  2. load_use=1: load_pc=0, load_if_id=0, load_id_ex=1 with squash_id_ex=1 (inserts a bubble), load_ex_mem=1, load_mem_wb=1.
  3. Otherwise: all five loads=1, no squash.
- Counters:
  - stall_cnt increments on each cycle with mem_stall=1 and wraps at 2^CNT_W.
  - The wait counter increments while advance=0 and clears on advance.
  - When the wait counter reaches TIMEOUT, timeout_err sets and stays set until rst.
- Reset mid-wait: state returns to RUN and the flags clear asynchronously. A pending cache response after reset is not tracked.
- Latency: all outputs except counters and timeout_err are combinational from inputs and state, so a response is acted on in the same cycle it arrives.

Decomposition:
- Shared package rv32i_types: enum pipe_ctrl_state_t {RUN, WAIT}. Also a pipe_ctrl_t struct bundling the five loads and two squashes, for reuse by the datapath top.
- Sub-module: pipeline_ctrl_perf (the two counters plus the watchdog), fed by mem_stall and the applied-redirect pulse.

Test Plan:
- Reset then idle inputs (imem_req=1, imem_resp=1 each cycle) -> all loads=1, squashes=0, mem_stall=0, stall_cnt stays 0.
- imem_req=1 with resp after 3 cycles, dmem_req=0 -> 3 cycles of all loads=0 and mem_stall=1; loads=1 on the resp cycle; stall_cnt=3.
- Overlapping misses: imem_resp at cycle 2, dmem_resp at cycle 5 -> i_done=1 during cycles 3-4, advance only at cycle 5, then i_done=0; stall_cnt=5.
- load_use=1 on an advancing cycle -> load_pc=0, load_if_id=0, load_id_ex=1, squash_id_ex=1; next cycle with load_use=0 all loads=1.
- redirect=1 together with load_use=1, both caches ready -> all loads=1, both squashes=1, flush_cnt 0->1. Repeat with redirect held during a 2-cycle D-miss -> squashes only on the advancing cycle, flush_cnt increments once.
- dmem_req=1 with no resp for TIMEOUT=8 cycles -> timeout_err=1 from the 8th stall cycle and stays set after a later dmem_resp. Asserting rst mid-stall clears state, flags, counters and timeout_err immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: sequencer state and the stage load/squash bundle.
package rv32i_types;

  // RUN: pipeline advancing; WAIT: frozen on at least one outstanding cache access.
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } pipe_ctrl_state_t;

  // Load and squash strobes for the PC and the four stage registers.
  // A squash only takes effect together with the load of the same register.
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic squash_if_id;
    logic squash_id_ex;
  } pipe_ctrl_t;

  // Everything held, nothing cleared.
  localparam pipe_ctrl_t CTRL_HOLD = '0;

  // Control word for an advancing cycle. A redirect wins over a load-use
  // hazard because the hazarding instruction in ID is flushed anyway.
  function automatic pipe_ctrl_t advance_ctrl(input logic redirect, input logic load_use);
    pipe_ctrl_t c;
    c = CTRL_HOLD;
    if (redirect) begin
      c.load_pc      = 1'b1;
      c.load_if_id   = 1'b1;
      c.load_id_ex   = 1'b1;
      c.load_ex_mem  = 1'b1;
      c.load_mem_wb  = 1'b1;
      c.squash_if_id = 1'b1;
      c.squash_id_ex = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into ID/EX, let the back end drain.
      c.load_id_ex   = 1'b1;
      c.squash_id_ex = 1'b1;
      c.load_ex_mem  = 1'b1;
      c.load_mem_wb  = 1'b1;
    end else begin
      c.load_pc      = 1'b1;
      c.load_if_id   = 1'b1;
      c.load_id_ex   = 1'b1;
      c.load_ex_mem  = 1'b1;
      c.load_mem_wb  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_perf.sv
// Stall/flush statistics and the memory-wait watchdog for the pipeline sequencer.
module pipeline_ctrl_perf
  import rv32i_types::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_stall,
  input  logic             flush_apply,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  // Wide enough to hold TIMEOUT itself; the counter saturates there.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_stall)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_apply) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Consecutive non-advancing cycles; saturates so it can never wrap back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!mem_stall) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky error, set on the edge where the wait count reaches TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (mem_stall && (wait_cnt >= WAIT_LAST)) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
// Handshake note: imem_req/dmem_req are level requests held until served;
// imem_resp/dmem_resp are single-cycle valid pulses with no back-pressure.
// A response that arrives while the other cache is still stalling is latched
// in i_done/d_done so the served side is not re-requested; both latches drop
// on the cycle the pipeline advances.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             redirect,
  input  logic             load_use,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             squash_if_id,
  output logic             squash_id_ex,
  output logic             mem_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  pipe_ctrl_state_t state_q, state_d;
  pipe_ctrl_t       ctrl;
  logic             i_done, d_done;
  logic             i_ok, d_ok, advance;
  logic             flush_apply;

  assign i_ok    = !imem_req | imem_resp | i_done;
  assign d_ok    = !dmem_req | dmem_resp | d_done;
  assign advance = i_ok & d_ok;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: freeze on any unserved access, resume on the advancing cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!advance) state_d = WAIT;
      WAIT:    if (advance)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Early-response latches; a response on the advancing cycle is consumed directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (advance) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (imem_resp) i_done <= 1'b1;
      if (dmem_resp) d_done <= 1'b1;
    end
  end

  // Stage strobes: all held during a memory wait or reset, prioritised otherwise.
  always_comb begin
    ctrl        = CTRL_HOLD;
    flush_apply = 1'b0;
    mem_stall   = 1'b0;
    if (!rst) begin
      mem_stall = !advance;
      if (advance) begin
        ctrl        = advance_ctrl(redirect, load_use);
        flush_apply = redirect;
      end
    end
  end

  assign load_pc      = ctrl.load_pc;
  assign load_if_id   = ctrl.load_if_id;
  assign load_id_ex   = ctrl.load_id_ex;
  assign load_ex_mem  = ctrl.load_ex_mem;
  assign load_mem_wb  = ctrl.load_mem_wb;
  assign squash_if_id = ctrl.squash_if_id;
  assign squash_id_ex = ctrl.squash_id_ex;

  pipeline_ctrl_perf #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .mem_stall  (mem_stall),
    .flush_apply(flush_apply),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .timeout_err(timeout_err)
  );

endmodule
